// File: rtl/lua_raster_scanner.sv
// Window command stage: walks a WinW x WinH rectangle, drives the linear address unit once per
// point and forwards each address downstream. Define LUA_RASTER_SCANNER_SERPENTINE_EN for boustrophedon order.
module lua_raster_scanner #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Go,
  input  logic [DATA_WIDTH-1:0] WinX,
  input  logic [DATA_WIDTH-1:0] WinY,
  input  logic [DATA_WIDTH-1:0] WinW,
  input  logic [DATA_WIDTH-1:0] WinH,
  output logic                  Busy,
  output logic                  Done,
  output logic [DATA_WIDTH-1:0] LuaX,
  output logic [DATA_WIDTH-1:0] LuaY,
  output logic                  LuaStart,
  input  logic                  LuaReady,
  input  logic [ADDR_WIDTH-1:0] LuaAddress,
  output logic [ADDR_WIDTH-1:0] AddrOut,
  output logic                  AddrValid,
  input  logic                  AddrAccept
);

  typedef enum logic [2:0] {
    StIdle, StWaitRdy, StReq, StWaitAck, StWaitRes, StEmit, StFinish
  } state_t;

  localparam logic [DATA_WIDTH-1:0] One = DATA_WIDTH'(1);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] win_w_q, win_w_d;
  logic [DATA_WIDTH-1:0] win_h_q, win_h_d;
  logic [DATA_WIDTH-1:0] cur_x_q, cur_x_d;
  logic [DATA_WIDTH-1:0] cur_y_q, cur_y_d;
  logic [DATA_WIDTH-1:0] col_q, col_d;
  logic [DATA_WIDTH-1:0] row_q, row_d;
  logic [DATA_WIDTH-1:0] lua_x_q, lua_x_d;
  logic [DATA_WIDTH-1:0] lua_y_q, lua_y_d;
  logic                  start_q, start_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  valid_q, valid_d;
  logic                  last_col, last_row;
`ifndef LUA_RASTER_SCANNER_SERPENTINE_EN
  logic [DATA_WIDTH-1:0] win_x_q, win_x_d;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      win_w_q <= '0;
      win_h_q <= '0;
      cur_x_q <= '0;
      cur_y_q <= '0;
      col_q   <= '0;
      row_q   <= '0;
      lua_x_q <= '0;
      lua_y_q <= '0;
      start_q <= 1'b0;
      addr_q  <= '0;
      valid_q <= 1'b0;
`ifndef LUA_RASTER_SCANNER_SERPENTINE_EN
      win_x_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      win_w_q <= win_w_d;
      win_h_q <= win_h_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      col_q   <= col_d;
      row_q   <= row_d;
      lua_x_q <= lua_x_d;
      lua_y_q <= lua_y_d;
      start_q <= start_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
`ifndef LUA_RASTER_SCANNER_SERPENTINE_EN
      win_x_q <= win_x_d;
`endif
    end
  end

  assign last_col = (col_q == win_w_q - One);
  assign last_row = (row_q == win_h_q - One);

  always_comb begin
    state_d = state_q;
    win_w_d = win_w_q;
    win_h_d = win_h_q;
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    col_d   = col_q;
    row_d   = row_q;
    lua_x_d = lua_x_q;
    lua_y_d = lua_y_q;
    start_d = start_q;
    addr_d  = addr_q;
    valid_d = valid_q;
`ifndef LUA_RASTER_SCANNER_SERPENTINE_EN
    win_x_d = win_x_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (Go) begin
`ifndef LUA_RASTER_SCANNER_SERPENTINE_EN
          win_x_d = WinX;
`endif
          win_w_d = WinW;
          win_h_d = WinH;
          cur_x_d = WinX;
          cur_y_d = WinY;
          col_d   = '0;
          row_d   = '0;
          state_d = (WinW == '0 || WinH == '0) ? StFinish : StWaitRdy;
        end
      end
      StWaitRdy: begin
        if (LuaReady) begin
          lua_x_d = cur_x_q;
          lua_y_d = cur_y_q;
          start_d = 1'b1;
          state_d = StReq;
        end
      end
      StReq: begin
        // Start stays up until the address unit shows it has taken the request.
        if (!LuaReady) begin
          start_d = 1'b0;
          state_d = StWaitAck;
        end
      end
      StWaitAck, StWaitRes: begin
        if (LuaReady) begin
          addr_d  = LuaAddress;
          valid_d = 1'b1;
          state_d = StEmit;
        end else begin
          state_d = StWaitRes;
        end
      end
      StEmit: begin
        if (AddrAccept) begin
          valid_d = 1'b0;
          if (last_col) begin
            col_d   = '0;
            row_d   = row_q + One;
            cur_y_d = cur_y_q + One;
`ifndef LUA_RASTER_SCANNER_SERPENTINE_EN
            cur_x_d = win_x_q;
`endif
          end else begin
            col_d = col_q + One;
`ifdef LUA_RASTER_SCANNER_SERPENTINE_EN
            cur_x_d = row_q[0] ? cur_x_q - One : cur_x_q + One;
`else
            cur_x_d = cur_x_q + One;
`endif
          end
          state_d = (last_col && last_row) ? StFinish : StWaitRdy;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  assign Busy      = (state_q != StIdle) && (state_q != StFinish);
  assign Done      = (state_q == StFinish);
  assign LuaX      = lua_x_q;
  assign LuaY      = lua_y_q;
  assign LuaStart  = start_q;
  assign AddrOut   = addr_q;
  assign AddrValid = valid_q;

endmodule
